// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - HD44780 bus owner: power-up init, enable timing, two-requester burst arbitration
module lcd_bus_arbiter #(
  parameter int EN_CYCLES   = 20,
  parameter int WAIT_CYCLES = 50000,
  parameter int CLEAR_WAIT  = 100000,
  parameter int INIT_WAIT   = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       busy,
  output logic       init_done
);

  localparam int MAX_A = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
  localparam int MAX_B = (WAIT_CYCLES > EN_CYCLES) ? WAIT_CYCLES : EN_CYCLES;
  localparam int MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CW-1:0] C_PWRUP_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] C_EN_LAST    = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] C_WAIT_LAST  = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] C_CLEAR_LAST = CW'(CLEAR_WAIT - 1);
  localparam logic [CW-1:0] C_ONE        = CW'(1);

  typedef enum logic [2:0] {S_PWRUP, S_SETUP, S_PULSE, S_EXEC, S_IDLE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_init_idx;
  logic [7:0]    r_lcd_data;
  logic          r_lcd_rs;
  logic          r_init_done;
  logic          r_lock;
  logic          r_lock_owner;
  logic          r_last_served;

  logic w_elig0;
  logic w_elig1;
  logic w_grant;
  logic w_hs;
  logic w_is_clear;
  logic w_exec_done;
  logic w_init_more;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // A held lock restricts eligibility to its owner even when the owner is momentarily idle
  assign w_elig0     = req0_valid & r_init_done & (~r_lock | ~r_lock_owner);
  assign w_elig1     = req1_valid & r_init_done & (~r_lock | r_lock_owner);
  assign w_grant     = (w_elig0 & w_elig1) ? ~r_last_served : w_elig1;
  assign w_hs        = (r_state == S_IDLE) & (w_elig0 | w_elig1);
  assign w_is_clear  = ~r_lcd_rs & ((r_lcd_data == 8'h01) | (r_lcd_data == 8'h02));
  assign w_exec_done = (r_cnt == (w_is_clear ? C_CLEAR_LAST : C_WAIT_LAST));
  assign w_init_more = ~r_init_done & (r_init_idx != 2'd3);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_PWRUP;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PWRUP: if (r_cnt == C_PWRUP_LAST) w_next = S_SETUP;
      S_SETUP: w_next = S_PULSE;
      S_PULSE: if (r_cnt == C_EN_LAST) w_next = S_EXEC;
      S_EXEC:  if (w_exec_done) w_next = w_init_more ? S_SETUP : S_IDLE;
      S_IDLE:  if (w_hs) w_next = S_SETUP;
      default: w_next = S_PWRUP;
    endcase
  end

  always_comb begin
    lcd_en     = (r_state == S_PULSE);
    busy       = (r_state != S_IDLE);
    req0_ready = w_hs & ~w_grant;
    req1_ready = w_hs & w_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_init_idx    <= 2'd0;
      r_lcd_data    <= 8'h00;
      r_lcd_rs      <= 1'b0;
      r_init_done   <= 1'b0;
      r_lock        <= 1'b0;
      r_lock_owner  <= 1'b0;
      r_last_served <= 1'b1;
    end else begin
      r_cnt <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + C_ONE;
      case (r_state)
        S_PWRUP: begin
          if (w_next == S_SETUP) begin
            r_lcd_data <= init_cmd(2'd0);
            r_lcd_rs   <= 1'b0;
            r_init_idx <= 2'd0;
          end
        end
        S_EXEC: begin
          if (w_exec_done) begin
            if (w_init_more) begin
              r_init_idx <= r_init_idx + 2'd1;
              r_lcd_data <= init_cmd(r_init_idx + 2'd1);
            end else if (!r_init_done) begin
              r_init_done <= 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (w_hs) begin
            r_lcd_data    <= w_grant ? req1_data : req0_data;
            r_lcd_rs      <= w_grant ? req1_rs : req0_rs;
            r_lock        <= ~(w_grant ? req1_last : req0_last);
            r_lock_owner  <= w_grant;
            r_last_served <= w_grant;
          end
        end
        default: ;
      endcase
    end
  end

  assign lcd_data  = r_lcd_data;
  assign lcd_rs    = r_lcd_rs;
  assign lcd_rw    = 1'b0;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - self-checking bench for lcd_bus_arbiter with a transaction-level reference model
module tb_lcd_bus_arbiter;

  localparam int EN   = 2;
  localparam int WT   = 5;
  localparam int CLR  = 8;
  localparam int IW   = 10;
  localparam int INIT_LEN = IW + 4 * (1 + EN) + 3 * WT + CLR;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       last;
    int         gap;
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_rs, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_en, lcd_rw, busy, init_done;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(
    .EN_CYCLES(EN), .WAIT_CYCLES(WT), .CLEAR_WAIT(CLR), .INIT_WAIT(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_rw(lcd_rw),
    .busy(busy), .init_done(init_done)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  item_t q0[$];
  item_t q1[$];
  int    p0 = 0;
  int    p1 = 0;
  int    log_q[$];
  bit    m_lock;
  int    m_owner;
  int    m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input logic rs, input logic [7:0] d, input logic last, input int gap);
    item_t it;
    it.rs = rs; it.data = d; it.last = last; it.gap = gap;
    return it;
  endfunction

  function automatic logic [7:0] exp_init_cmd(input int k);
    case (k)
      0:       return 8'h38;
      1:       return 8'h0C;
      2:       return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Arbitration rule: lock owner only; otherwise the requester not served most recently wins a tie
  function automatic int pick(input bit v0, input bit v1);
    if (m_lock) begin
      if (m_owner == 0) return v0 ? 0 : -1;
      return v1 ? 1 : -1;
    end
    if (v0 && v1) return (m_last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic drive_inputs();
    req0_valid = (q0.size() > 0) && (p0 == 0);
    req1_valid = (q1.size() > 0) && (p1 == 0);
    if (q0.size() > 0) begin
      req0_rs = q0[0].rs; req0_data = q0[0].data; req0_last = q0[0].last;
    end else begin
      req0_rs = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    end
    if (q1.size() > 0) begin
      req1_rs = q1[0].rs; req1_data = q1[0].data; req1_last = q1[0].last;
    end else begin
      req1_rs = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_inputs();
    if (p0 > 0) p0--;
    if (p1 > 0) p1--;
    cyc++;
    @(negedge clk);
  endtask

  task automatic arm();
    if (q0.size() > 0) p0 = q0[0].gap;
    if (q1.size() > 0) p1 = q1[0].gap;
  endtask

  task automatic gen(input int r, input int nbursts);
    for (int b = 0; b < nbursts; b++) begin
      int len;
      len = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) begin
        item_t it;
        it.rs   = 1'($urandom_range(0, 1));
        it.data = 8'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          it.rs   = 1'b0;
          it.data = 8'($urandom_range(1, 2));
        end
        it.last = (i == len - 1);
        it.gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
        if (r == 0) q0.push_back(it);
        else        q1.push_back(it);
      end
    end
  endtask

  // Checks one byte's bus waveform starting from the cycle of its handshake
  task automatic check_byte(input logic [7:0] d, input logic rs);
    int wt;
    wt = (!rs && (d == 8'h01 || d == 8'h02)) ? CLR : WT;
    tick();
    chk("setup_en", lcd_en, 1'b0);
    chk("setup_data", lcd_data, d);
    chk("setup_rs", lcd_rs, rs);
    chk("setup_busy", busy, 1'b1);
    for (int i = 0; i < EN; i++) begin
      tick();
      chk("pulse_en", lcd_en, 1'b1);
      chk("pulse_data", lcd_data, d);
      chk("pulse_ready", {req0_ready, req1_ready}, 2'b00);
    end
    for (int i = 0; i < wt; i++) begin
      tick();
      chk("exec_en", lcd_en, 1'b0);
      chk("exec_data", {lcd_rs, lcd_data}, {rs, d});
      chk("exec_busy", busy, 1'b1);
      chk("exec_ready", {req0_ready, req1_ready}, 2'b00);
    end
    tick();
    chk("byte_done_busy", busy, 1'b0);
  endtask

  task automatic run_traffic(input int budget);
    int    deadline;
    int    w;
    item_t it;
    deadline = cyc + budget;
    while ((q0.size() > 0 || q1.size() > 0) && cyc < deadline) begin
      chk("idle_busy", busy, 1'b0);
      chk("idle_rw", lcd_rw, 1'b0);
      w = pick(req0_valid, req1_valid);
      chk("ready0", req0_ready, w == 0);
      chk("ready1", req1_ready, w == 1);
      if (w < 0) begin
        tick();
      end else begin
        if (w == 0) begin
          it = q0.pop_front();
          if (q0.size() > 0) p0 = q0[0].gap;
        end else begin
          it = q1.pop_front();
          if (q1.size() > 0) p1 = q1[0].gap;
        end
        m_last  = w;
        m_owner = w;
        m_lock  = !it.last;
        log_q.push_back(w);
        check_byte(it.data, it.rs);
      end
    end
    chk("traffic_drained", q0.size() + q1.size(), 0);
  endtask

  task automatic check_order(input string tag, input int n, input logic [7:0] pat);
    chk({tag, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) chk(tag, log_q[i], pat[i]);
  endtask

  task automatic reset_and_init();
    reset = 1'b1;
    tick();
    chk("rst_en", lcd_en, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("rst_busy", busy, 1'b1);
    chk("rst_init_done", init_done, 1'b0);
    tick();
    m_lock  = 1'b0;
    m_owner = 0;
    m_last  = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_inputs();
    @(negedge clk);
    for (int c = 0; c <= INIT_LEN; c++) begin
      logic       exp_en;
      logic [7:0] exp_d;
      bit         d_known;
      if (c > 0) tick();
      exp_en  = 1'b0;
      exp_d   = 8'h00;
      d_known = (c < IW);
      for (int k = 0; k < 4; k++) begin
        int s;
        int e;
        s = IW + 1 + k * (1 + EN + WT);
        e = s + EN + ((k == 3) ? CLR : WT) - 1;
        if (c >= s && c < s + EN) exp_en = 1'b1;
        if (c >= s - 1 && c <= e) begin
          exp_d   = exp_init_cmd(k);
          d_known = 1'b1;
        end
      end
      chk("init_en", lcd_en, exp_en);
      chk("init_busy", busy, c < INIT_LEN);
      chk("init_done", init_done, c >= INIT_LEN);
      if (d_known) chk("init_bus", {lcd_rs, lcd_data}, {1'b0, exp_d});
      if (c < INIT_LEN) chk("init_ready", {req0_ready, req1_ready}, 2'b00);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_inputs();

    reset_and_init();

    log_q.delete();
    q0.push_back(mk(1'b0, 8'h80, 1'b1, 0));
    arm();
    run_traffic(200);
    check_order("single_req0", 1, 8'b0);

    // Requests posted during init must wait, then alternate from the first idle cycle
    log_q.delete();
    q0.push_back(mk(1'b1, 8'h41, 1'b1, 0));
    q0.push_back(mk(1'b1, 8'h42, 1'b1, 0));
    q1.push_back(mk(1'b1, 8'h30, 1'b1, 0));
    arm();
    reset_and_init();
    run_traffic(300);
    check_order("alternate", 3, 8'b010);

    log_q.delete();
    q1.push_back(mk(1'b0, 8'hC0, 1'b0, 0));
    q1.push_back(mk(1'b1, 8'h31, 1'b0, 0));
    q1.push_back(mk(1'b1, 8'h32, 1'b1, 0));
    q0.push_back(mk(1'b1, 8'h58, 1'b1, 0));
    arm();
    run_traffic(300);
    check_order("burst_lock", 4, 8'b0111);

    log_q.delete();
    q1.push_back(mk(1'b0, 8'hC0, 1'b0, 0));
    q1.push_back(mk(1'b1, 8'h31, 1'b0, 20));
    q1.push_back(mk(1'b1, 8'h32, 1'b1, 0));
    q0.push_back(mk(1'b1, 8'h59, 1'b1, 0));
    arm();
    run_traffic(400);
    check_order("lock_stall", 4, 8'b0111);

    gen(0, 8);
    gen(1, 8);
    arm();
    run_traffic(4000);

    q1.push_back(mk(1'b0, 8'hC0, 1'b0, 0));
    q1.push_back(mk(1'b1, 8'h31, 1'b1, 0));
    arm();
    tick();
    chk("pre_reset_ready1", req1_ready, 1'b1);
    tick();
    tick();
    chk("pre_reset_pulse", lcd_en, 1'b1);
    q0.delete();
    q1.delete();
    p0 = 0;
    p1 = 0;
    reset_and_init();

    log_q.delete();
    q0.push_back(mk(1'b1, 8'h5A, 1'b1, 0));
    arm();
    run_traffic(200);
    check_order("lock_cleared", 1, 8'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
